// File: rtl/inst_encoder_if.sv
// Request/response bundle for inst_encoder: instruction fields in, encoded words with byte addresses out.
// The slave modport is the encoder's side. The master modport is the loader's or bench's side.
interface inst_encoder_if #(
  parameter int DEPTH = 4
);
  logic                     req_valid;
  logic                     req_ready;
  logic [2:0]               req_kind;
  logic [2:0]               req_funct3;
  logic                     req_f7b5;
  logic [4:0]               req_rd;
  logic [4:0]               req_rs1;
  logic [4:0]               req_rs2;
  logic [31:0]              req_imm;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_inst;
  logic [31:0]              out_addr;
  logic [$clog2(DEPTH):0]   level;
  logic                     err_illegal;

  modport master (
    output req_valid, req_kind, req_funct3, req_f7b5, req_rd, req_rs1, req_rs2, req_imm, out_ready,
    input  req_ready, out_valid, out_inst, out_addr, level, err_illegal
  );

  modport slave (
    input  req_valid, req_kind, req_funct3, req_f7b5, req_rd, req_rs1, req_rs2, req_imm, out_ready,
    output req_ready, out_valid, out_inst, out_addr, level, err_illegal
  );
endinterface

// File: rtl/inst_encoder.sv
// RV32I field packer feeding a DEPTH-entry FIFO; an accepted word is visible on out_* one cycle later, with no req->out comb path.
// Backpressure: req_ready drops only when the FIFO is full, and a same-cycle pop does not reopen it.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_vld,
  output logic                       push_rdy,
  input  logic [WIDTH-1:0]           push_dat,
  output logic                       pop_vld,
  input  logic                       pop_rdy,
  output logic [WIDTH-1:0]           pop_dat,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_fire, pop_fire;

  assign push_rdy  = (level_q != (AW+1)'(DEPTH));
  assign pop_vld   = (level_q != '0);
  assign push_fire = push_vld && push_rdy;
  assign pop_fire  = pop_vld && pop_rdy;
  // Gating the output keeps out_inst at zero while the queue is empty.
  assign pop_dat   = pop_vld ? mem_q[rd_ptr_q] : '0;
  assign level     = level_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_fire) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_fire) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_fire && !pop_fire) begin
      level_d = level_q + (AW+1)'(1);
    end else if (!push_fire && pop_fire) begin
      level_d = level_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

module inst_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset,
  inst_encoder_if.slave  bus
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [31:0] enc_word;
  logic        fifo_push_rdy, fifo_pop_vld;
  logic        req_fire, illegal_fire;
  logic [31:0] out_addr_q, out_addr_d;
  logic        err_illegal_q, err_illegal_d;
  logic        unused_imm_hi;

  // Immediate bits above the widest format (JAL, bit 20) are dropped.
  assign unused_imm_hi = ^bus.req_imm[31:21];

  always_comb begin
    enc_word = '0;
    case (bus.req_kind)
      3'd0: enc_word = {1'b0, bus.req_f7b5, 5'b0, bus.req_rs2, bus.req_rs1, bus.req_funct3, bus.req_rd, OP_R};
      3'd1: enc_word = {bus.req_imm[11:0], bus.req_rs1, bus.req_funct3, bus.req_rd, OP_LOAD};
      3'd2: enc_word = {bus.req_imm[11:5], bus.req_rs2, bus.req_rs1, bus.req_funct3,
                        bus.req_imm[4:0], OP_STORE};
      3'd3: enc_word = {bus.req_imm[12], bus.req_imm[10:5], bus.req_rs2, bus.req_rs1, bus.req_funct3,
                        bus.req_imm[4:1], bus.req_imm[11], OP_BRANCH};
      3'd4: begin
        case (bus.req_funct3)
          3'b001:  enc_word = {7'b0, bus.req_imm[4:0], bus.req_rs1, bus.req_funct3, bus.req_rd, OP_OPIMM};
          3'b101:  enc_word = {1'b0, bus.req_f7b5, 5'b0, bus.req_imm[4:0], bus.req_rs1, bus.req_funct3,
                               bus.req_rd, OP_OPIMM};
          default: enc_word = {bus.req_imm[11:0], bus.req_rs1, bus.req_funct3, bus.req_rd, OP_OPIMM};
        endcase
      end
      3'd5: enc_word = {bus.req_imm[11:0], bus.req_rs1, 3'b000, bus.req_rd, OP_JALR};
      3'd6: enc_word = {bus.req_imm[20], bus.req_imm[10:1], bus.req_imm[11], bus.req_imm[19:12],
                        bus.req_rd, OP_JAL};
      default: enc_word = '0;
    endcase
  end

  // Kind 7 still completes the handshake; it only raises the sticky error.
  assign req_fire     = bus.req_valid && fifo_push_rdy;
  assign illegal_fire = req_fire && (bus.req_kind == 3'd7);

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (bus.req_valid && (bus.req_kind != 3'd7)),
    .push_rdy (fifo_push_rdy),
    .push_dat (enc_word),
    .pop_vld  (fifo_pop_vld),
    .pop_rdy  (bus.out_ready),
    .pop_dat  (bus.out_inst),
    .level    (bus.level)
  );

  always_comb begin
    out_addr_d    = out_addr_q;
    err_illegal_d = err_illegal_q || illegal_fire;
    if (fifo_pop_vld && bus.out_ready) begin
      out_addr_d = out_addr_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_addr_q    <= BASE_ADDR;
      err_illegal_q <= 1'b0;
    end else begin
      out_addr_q    <= out_addr_d;
      err_illegal_q <= err_illegal_d;
    end
  end

  assign bus.req_ready   = fifo_push_rdy;
  assign bus.out_valid   = fifo_pop_vld;
  assign bus.out_addr    = out_addr_q;
  assign bus.err_illegal = err_illegal_q;
endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: two instances (BASE_ADDR 0 and 0xFFFFFFF8) share stimulus and are compared
// every cycle against a queue-based model, plus literal expectations for known encodings.
module tb_inst_encoder;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE1 = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, out_ready, req_f7b5;
  logic [2:0]  req_kind, req_funct3;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [31:0] req_imm;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  inst_encoder_if #(.DEPTH(DEPTH)) if0 ();
  inst_encoder_if #(.DEPTH(DEPTH)) if1 ();

  assign if0.req_valid = req_valid;   assign if1.req_valid = req_valid;
  assign if0.req_kind = req_kind;     assign if1.req_kind = req_kind;
  assign if0.req_funct3 = req_funct3; assign if1.req_funct3 = req_funct3;
  assign if0.req_f7b5 = req_f7b5;     assign if1.req_f7b5 = req_f7b5;
  assign if0.req_rd = req_rd;         assign if1.req_rd = req_rd;
  assign if0.req_rs1 = req_rs1;       assign if1.req_rs1 = req_rs1;
  assign if0.req_rs2 = req_rs2;       assign if1.req_rs2 = req_rs2;
  assign if0.req_imm = req_imm;       assign if1.req_imm = req_imm;
  assign if0.out_ready = out_ready;   assign if1.out_ready = out_ready;

  inst_encoder #(.DEPTH(DEPTH)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  inst_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoding from the ISA field layout, built by shifting and masking.
  function automatic logic [31:0] enc(input logic [2:0] k, input logic [2:0] f3, input logic f7,
                                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [31:0] i);
    logic [31:0] d, fn, s1, s2, f7s;
    d = 32'(rd) << 7;  fn = 32'(f3) << 12;  s1 = 32'(rs1) << 15;  s2 = 32'(rs2) << 20;
    f7s = 32'(f7) << 30;
    case (k)
      3'd0: return 32'h33 | d | fn | s1 | s2 | f7s;
      3'd1: return 32'h03 | d | fn | s1 | ((i & 32'hFFF) << 20);
      3'd2: return 32'h23 | ((i & 32'h1F) << 7) | fn | s1 | s2 | (((i >> 5) & 32'h7F) << 25);
      3'd3: return 32'h63 | (((i >> 11) & 32'h1) << 7) | (((i >> 1) & 32'hF) << 8) | fn | s1 | s2
                   | (((i >> 5) & 32'h3F) << 25) | (((i >> 12) & 32'h1) << 31);
      3'd4: begin
        if (f3 == 3'd1) return 32'h13 | d | fn | s1 | ((i & 32'h1F) << 20);
        if (f3 == 3'd5) return 32'h13 | d | fn | s1 | ((i & 32'h1F) << 20) | f7s;
        return 32'h13 | d | fn | s1 | ((i & 32'hFFF) << 20);
      end
      3'd5: return 32'h67 | d | s1 | ((i & 32'hFFF) << 20);
      3'd6: return 32'h6F | d | (((i >> 12) & 32'hFF) << 12) | (((i >> 11) & 32'h1) << 20)
                   | (((i >> 1) & 32'h3FF) << 21) | (((i >> 20) & 32'h1) << 31);
      default: return 32'h0;
    endcase
  endfunction

  // Reference model: a queue of pending words plus one address counter per instance.
  logic [31:0] mq[$];
  logic [31:0] m_addr0 = 32'h0;
  logic [31:0] m_addr1 = BASE1;
  bit          m_err = 0;

  always @(posedge clk) begin
    bit can_push, do_pop;
    if (reset) begin
      mq.delete();
      m_addr0 = 32'h0;
      m_addr1 = BASE1;
      m_err = 0;
    end else begin
      can_push = (mq.size() != DEPTH);
      do_pop   = (mq.size() != 0) && out_ready;
      if (do_pop) begin
        void'(mq.pop_front());
        m_addr0 = m_addr0 + 32'd4;
        m_addr1 = m_addr1 + 32'd4;
      end
      if (req_valid && can_push) begin
        if (req_kind == 3'd7) m_err = 1;
        else mq.push_back(enc(req_kind, req_funct3, req_f7b5, req_rd, req_rs1, req_rs2, req_imm));
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("level0", 32'(if0.level), 32'(mq.size()));
      check("level1", 32'(if1.level), 32'(mq.size()));
      check("req_ready", 32'(if0.req_ready), 32'(mq.size() != DEPTH));
      check("out_valid", 32'(if0.out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        check("out_inst0", if0.out_inst, mq[0]);
        check("out_inst1", if1.out_inst, mq[0]);
      end
      check("out_addr0", if0.out_addr, m_addr0);
      check("out_addr1", if1.out_addr, m_addr1);
      check("err0", 32'(if0.err_illegal), 32'(m_err));
      check("err1", 32'(if1.err_illegal), 32'(m_err));
    end
  end

  task automatic set_fields(input logic [2:0] k, input logic [2:0] f3, input logic f7,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] imm);
    req_kind = k; req_funct3 = f3; req_f7b5 = f7;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
  endtask

  task automatic rand_fields(input int max_kind);
    set_fields(3'($urandom_range(0, max_kind)), 3'($urandom), 1'($urandom), 5'($urandom),
               5'($urandom), 5'($urandom), $urandom());
  endtask

  task automatic send(input logic [2:0] k, input logic [2:0] f3, input logic f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm);
    set_fields(k, f3, f7, rd, rs1, rs2, imm);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] saved [DEPTH];
    reset = 1'b1; req_valid = 1'b0; out_ready = 1'b0;
    set_fields(3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    @(posedge clk); #1;
    chk_en = 1;
    @(negedge clk);
    check("rst_level", 32'(if0.level), 32'd0);
    check("rst_valid", 32'(if0.out_valid), 32'd0);
    check("rst_inst", if0.out_inst, 32'h0);
    check("rst_addr0", if0.out_addr, 32'h0);
    check("rst_addr1", if1.out_addr, 32'hFFFF_FFF8);
    check("rst_ready", 32'(if0.req_ready), 32'd1);
    check("rst_err", 32'(if0.err_illegal), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;

    // Known encodings, each visible one cycle after acceptance.
    send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    @(negedge clk); check("enc_r", if0.out_inst, 32'h002081B3); check("addr_r", if0.out_addr, 32'd0);
    check("addr_r1", if1.out_addr, 32'hFFFF_FFF8);
    send(3'd1, 3'd2, 1'b0, 5'd5, 5'd2, 5'd0, 32'd8);
    @(negedge clk); check("enc_load", if0.out_inst, 32'h00812283); check("addr_load", if0.out_addr, 32'd4);
    send(3'd2, 3'd2, 1'b0, 5'd0, 5'd2, 5'd5, 32'd12);
    @(negedge clk); check("enc_store", if0.out_inst, 32'h00512623);
    send(3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
    @(negedge clk); check("enc_branch", if0.out_inst, 32'hFE208EE3);
    send(3'd6, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
    @(negedge clk); check("enc_jal", if0.out_inst, 32'h008000EF);
    send(3'd4, 3'd5, 1'b1, 5'd4, 5'd4, 5'd0, 32'd3);
    @(negedge clk); check("enc_srai", if0.out_inst, 32'h40325213); check("addr_srai", if0.out_addr, 32'd20);
    @(posedge clk); #1;

    // Fill to DEPTH with the sink stalled, then confirm order and address stepping on release.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rand_fields(6);
      saved[i] = enc(req_kind, req_funct3, req_f7b5, req_rd, req_rs1, req_rs2, req_imm);
      req_valid = 1'b1;
      @(posedge clk); #1;
    end
    rand_fields(6);
    @(negedge clk);
    check("full_level", 32'(if0.level), DEPTH);
    check("full_ready", 32'(if0.req_ready), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check("drain_inst", if0.out_inst, saved[i]);
      check("drain_addr", if0.out_addr, 32'd24 + 32'(4 * i));
    end
    @(posedge clk); #1;

    // Address wrap on the high-base instance.
    pulse_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin rand_fields(6); req_valid = 1'b1; @(posedge clk); #1; end
    req_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); check("wrap_a", if1.out_addr, 32'hFFFF_FFF8);
    @(negedge clk); check("wrap_b", if1.out_addr, 32'hFFFF_FFFC);
    @(negedge clk); check("wrap_c", if1.out_addr, 32'h0000_0000);
    @(posedge clk); #1;

    // Steady push+pop at level 2.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin rand_fields(6); req_valid = 1'b1; @(posedge clk); #1; end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_fields(6);
      @(negedge clk); check("steady_level", 32'(if0.level), 32'd2);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Illegal kind, then reset with words queued and a request pending in the same cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin rand_fields(6); req_valid = 1'b1; @(posedge clk); #1; end
    send(3'd7, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    @(negedge clk);
    check("ill_level", 32'(if0.level), 32'd2);
    check("ill_err", 32'(if0.err_illegal), 32'd1);
    rand_fields(6); req_valid = 1'b1;
    @(posedge clk); #1;
    pulse_reset();
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_q_level", 32'(if0.level), 32'd0);
    check("rst_q_valid", 32'(if0.out_valid), 32'd0);
    check("rst_q_err", 32'(if0.err_illegal), 32'd0);

    // Randomized traffic, including occasional illegal kinds and resets.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      rand_fields(($urandom_range(0, 19) == 0) ? 7 : 6);
      req_valid = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 9) < 6);
      reset     = ($urandom_range(0, 149) == 0);
    end
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
